regfile_scoreboard: RTL and testbench
=====================================

// Module: regfile_scoreboard
// PURPOSE
//  Parametrised successor to the single-cycle NPC register file. Provides NRD
//  combinational read ports, one write (writeback) port, optional write-to-read
//  bypass and a per-register busy scoreboard for multi-cycle producers (loads,
//  mul/div). Sits between IDU (reads, issue) and the EXU/LSU writeback path.
// PARAMETERS
//  XLEN    64  data width of each register
//  NREG    32  number of architectural registers (power of 2, >=2)
//  NRD     2   number of read ports
//  BYPASS  1   1: same-cycle writeback data forwarded to reads; 0: no forwarding
//  AW      $clog2(NREG)       register address width (derived, do not override)
//  CW      $clog2(NREG+1)     busy-count width (derived, do not override)
// PORTS
//  clk        in   1        clock, all state updates on posedge
//  rst        in   1        reset, synchronous, active-high
//  rd_addr    in   NRD*AW   read addresses, port i at [i*AW +: AW]
//  rd_data    out  NRD*XLEN read data, port i at [i*XLEN +: XLEN]
//  rd_busy    out  NRD      1: register on port i has a pending producer
//  wr_en      in   1        writeback strobe
//  wr_addr    in   AW       writeback destination
//  wr_data    in   XLEN     writeback data
//  issue_en   in   1        request to mark issue_rd busy (producer issued)
//  issue_rd   in   AW       destination of issued producer
//  issue_ok   out  1        1: issue_rd may be claimed this cycle (no WAW hazard)
//  flush      in   1        clear all busy bits (pipeline kill); data untouched
//  busy_cnt   out  CW       number of registers currently marked busy
// BEHAVIOUR
//  - Reset (rst=1 at posedge): all registers <= 0, all busy bits <= 0,
//    busy_cnt <= 0. rst overrides wr_en, issue_en, flush in the same cycle.
//  - Register 0: reads always return 0, never busy, writes/issues to it ignored.
//  - Reads combinational, zero latency. BYPASS=1: if wr_en && wr_addr==rd_addr
//    && rd_addr!=0 then rd_data=wr_data and rd_busy=0 in that cycle. BYPASS=0:
//    read returns stored value; new value visible the cycle after the write.
//  - Write: wr_en at posedge stores wr_data into reg[wr_addr] and clears
//    busy[wr_addr]. Write to a non-busy register is legal (ALU result).
//  - issue_ok = (issue_rd==0) | ~busy[issue_rd] | (wr_en & wr_addr==issue_rd).
//    Combinational; does not depend on issue_en.
//  - Issue: issue_en && issue_ok && issue_rd!=0 sets busy[issue_rd] at posedge.
//    issue_en with issue_ok=0 is dropped (no state change); the requester stalls.
//  - Simultaneous write and issue to same reg: data written AND busy stays 1
//    (new producer wins over retiring one).
//  - flush: all busy bits <= 0 at posedge; a concurrent wr_en still writes data;
//    a concurrent issue is dropped (flush wins).
//  - busy_cnt: registered, equals popcount of busy bits after each posedge;
//    updated incrementally (+1 issue, -1 clear of set bit, net 0 when both hit
//    the same reg); reset/flush force 0. Never exceeds NREG-1.
//  - Per-port outputs independent; two ports reading the same reg give equal
//    data and busy.
// TESTING
//  1 Reset then read all regs on every port -> rd_data=0, rd_busy=0,
//    busy_cnt=0, issue_ok=1.
//  2 Write x5=0xDEAD_BEEF_0000_0001, read x5 same cycle: BYPASS=1 -> new value;
//    BYPASS=0 -> 0, then new value next cycle; write x0=0x1234 -> x0 reads 0.
//  3 Issue x7 -> next cycle rd_busy=1 for x7, busy_cnt=1, issue_ok(x7)=0;
//    second issue x7 dropped; writeback x7=0x42 -> busy clears, busy_cnt=0.
//  4 Same cycle: x9 busy, wr_en x9=0x99 and issue_en x9 -> x9 reads 0x99,
//    still busy, busy_cnt unchanged.
//  5 Issue x1,x2,x3 over 3 cycles (busy_cnt=3), then flush with wr_en x2=0x7
//    -> all busy 0, busy_cnt=0, x2 reads 0x7.
//  6 rst asserted while x4 busy and wr_en x4=0x55 -> x4 reads 0, not busy.

Source files
------------

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - register file with write bypass and per-register busy scoreboard
module regfile_scoreboard #(
  parameter int XLEN   = 64,
  parameter int NREG   = 32,
  parameter int NRD    = 2,
  parameter int BYPASS = 1,
  parameter int AW     = $clog2(NREG),
  parameter int CW     = $clog2(NREG + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic                wr_en,
  input  logic [AW-1:0]       wr_addr,
  input  logic [XLEN-1:0]     wr_data,
  input  logic                issue_en,
  input  logic [AW-1:0]       issue_rd,
  output logic                issue_ok,
  input  logic                flush,
  output logic [CW-1:0]       busy_cnt
);

  // Architectural state; entry 0 is never written so it stays zero after reset.
  logic [XLEN-1:0] r_regs [NREG];
  logic [NREG-1:0] r_busy;
  logic [CW-1:0]   r_busy_cnt;

  logic            w_issue_set;
  logic            w_wr_clr;
  logic [NREG-1:0] w_busy_next;

  // A writeback to the destination releases the old producer, so a new one may claim it.
  assign issue_ok = (issue_rd == '0) | ~r_busy[issue_rd] | (wr_en & (wr_addr == issue_rd));

  // Flush kills in-flight issues, so an issue in the flush cycle never lands.
  assign w_issue_set = issue_en & issue_ok & (issue_rd != '0) & ~flush;

  // Only a clear of a bit that is actually set lowers the busy count.
  assign w_wr_clr = wr_en & (wr_addr != '0) & r_busy[wr_addr];

  assign busy_cnt = r_busy_cnt;

  // Read ports: x0 hardwired to zero, optional same-cycle forwarding from writeback.
  for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
    logic [AW-1:0] w_addr;
    logic          w_hit;
    assign w_addr = rd_addr[gi*AW +: AW];
    assign w_hit  = (BYPASS != 0) && wr_en && (wr_addr == w_addr) && (w_addr != '0);
    assign rd_data[gi*XLEN +: XLEN] = (w_addr == '0) ? '0 : (w_hit ? wr_data : r_regs[w_addr]);
    assign rd_busy[gi] = w_hit ? 1'b0 : r_busy[w_addr];
  end

  // Next busy vector: retire first, then issue, so a new producer wins on the same register.
  always_comb begin
    w_busy_next = r_busy;
    if (wr_en) begin
      w_busy_next[wr_addr] = 1'b0;
    end
    if (w_issue_set) begin
      w_busy_next[issue_rd] = 1'b1;
    end
    w_busy_next[0] = 1'b0;
  end

  // Register data: writeback stores into any nonzero destination, flush does not affect data.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        r_regs[i] <= '0;
      end
    end else if (wr_en && (wr_addr != '0)) begin
      r_regs[wr_addr] <= wr_data;
    end
  end

  // Busy scoreboard: reset and flush clear every pending producer.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_next;
    end
  end

  // Busy count tracked incrementally; retire+issue on one set register nets to zero.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_busy_cnt <= '0;
    end else begin
      r_busy_cnt <= r_busy_cnt + {{(CW-1){1'b0}}, w_issue_set} - {{(CW-1){1'b0}}, w_wr_clr};
    end
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb/tb_regfile_scoreboard.sv - directed and random checks of regfile_scoreboard against a model
module tb_regfile_scoreboard;

  logic         clk = 1'b0;
  logic         rst;
  logic [9:0]   rd_addr;
  logic [127:0] rd_data;
  logic [1:0]   rd_busy;
  logic         wr_en;
  logic [4:0]   wr_addr;
  logic [63:0]  wr_data;
  logic         issue_en;
  logic [4:0]   issue_rd;
  logic         issue_ok;
  logic         flush;
  logic [5:0]   busy_cnt;

  int total = 0;
  int bad   = 0;

  logic [63:0] m_regs [32];
  bit          m_busy [32];

  regfile_scoreboard dut (
    .clk      (clk),
    .rst      (rst),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_busy  (rd_busy),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .issue_en (issue_en),
    .issue_rd (issue_rd),
    .issue_ok (issue_ok),
    .flush    (flush),
    .busy_cnt (busy_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] exp_data(input logic [4:0] a);
    if (a == 0) return 64'd0;
    if (wr_en && wr_addr == a) return wr_data;
    return m_regs[a];
  endfunction

  function automatic logic exp_busy(input logic [4:0] a);
    if (a == 0) return 1'b0;
    if (wr_en && wr_addr == a) return 1'b0;
    return m_busy[a];
  endfunction

  function automatic logic exp_ok();
    return (issue_rd == 0) || !m_busy[issue_rd] || (wr_en && wr_addr == issue_rd);
  endfunction

  function automatic int popcount();
    int n = 0;
    for (int i = 0; i < 32; i++) n += m_busy[i] ? 1 : 0;
    return n;
  endfunction

  task automatic model_clear_busy();
    for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
  endtask

  // check combinational outputs, clock once, advance the model, check the busy count
  task automatic step();
    logic ok;
    #1;
    for (int p = 0; p < 2; p++) begin
      chk("rd_data", rd_data[p*64 +: 64], exp_data(rd_addr[p*5 +: 5]));
      chk("rd_busy", {63'd0, rd_busy[p]}, {63'd0, exp_busy(rd_addr[p*5 +: 5])});
    end
    ok = exp_ok();
    chk("issue_ok", {63'd0, issue_ok}, {63'd0, ok});
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 32; i++) m_regs[i] = 64'd0;
      model_clear_busy();
    end else begin
      if (wr_en && wr_addr != 0) begin
        m_regs[wr_addr] = wr_data;
        m_busy[wr_addr] = 1'b0;
      end
      if (flush) model_clear_busy();
      else if (issue_en && ok && issue_rd != 0) m_busy[issue_rd] = 1'b1;
    end
    #1;
    chk("busy_cnt", {58'd0, busy_cnt}, 64'(popcount()));
  endtask

  task automatic idle();
    wr_en = 0; issue_en = 0; flush = 0; rst = 0;
  endtask

  initial begin
    rst = 1; wr_en = 0; wr_addr = 0; wr_data = 0; issue_en = 0; issue_rd = 0;
    flush = 0; rd_addr = 0;
    for (int i = 0; i < 32; i++) m_regs[i] = 64'd0;
    model_clear_busy();
    @(posedge clk);
    #1;
    rst = 0;

    // 1: everything reads zero and idle after reset
    chk("t1_cnt", {58'd0, busy_cnt}, 64'd0);
    for (int r = 0; r < 32; r++) begin
      rd_addr = {r[4:0], r[4:0]};
      issue_rd = r[4:0];
      #1;
      chk("t1_ok", {63'd0, issue_ok}, 64'd1);
      chk("t1_data", rd_data[127:64], 64'd0);
      step();
    end

    // 2: bypass of writeback, x0 stays zero
    rd_addr = {5'd5, 5'd5};
    wr_en = 1; wr_addr = 5; wr_data = 64'hDEAD_BEEF_0000_0001;
    #1;
    chk("t2_bypass", rd_data[63:0], 64'hDEAD_BEEF_0000_0001);
    chk("t2_bypass_busy", {62'd0, rd_busy}, 64'd0);
    step();
    idle();
    #1;
    chk("t2_stored", rd_data[127:64], 64'hDEAD_BEEF_0000_0001);
    rd_addr = 0; wr_en = 1; wr_addr = 0; wr_data = 64'h1234;
    step();
    idle();
    #1;
    chk("t2_x0", rd_data[63:0], 64'd0);

    // 3: issue x7, duplicate issue dropped, writeback retires it
    issue_en = 1; issue_rd = 7; rd_addr = {5'd7, 5'd7};
    step();
    idle();
    #1;
    chk("t3_busy", {62'd0, rd_busy}, 64'd3);
    chk("t3_cnt", {58'd0, busy_cnt}, 64'd1);
    chk("t3_ok", {63'd0, issue_ok}, 64'd0);
    issue_en = 1;
    step();
    idle();
    #1;
    chk("t3_dup_cnt", {58'd0, busy_cnt}, 64'd1);
    wr_en = 1; wr_addr = 7; wr_data = 64'h42;
    step();
    idle();
    #1;
    chk("t3_clr_busy", {62'd0, rd_busy}, 64'd0);
    chk("t3_clr_cnt", {58'd0, busy_cnt}, 64'd0);
    chk("t3_data", rd_data[63:0], 64'h42);

    // 4: retire and reissue the same register in one cycle
    issue_en = 1; issue_rd = 9; rd_addr = {5'd9, 5'd9};
    step();
    idle();
    wr_en = 1; wr_addr = 9; wr_data = 64'h99; issue_en = 1; issue_rd = 9;
    step();
    idle();
    #1;
    chk("t4_data", rd_data[63:0], 64'h99);
    chk("t4_busy", {63'd0, rd_busy[1]}, 64'd1);
    chk("t4_cnt", {58'd0, busy_cnt}, 64'd1);
    wr_en = 1; wr_addr = 9; wr_data = 64'h100;
    step();
    idle();

    // 5: three producers then flush with a concurrent write and a dropped issue
    for (int r = 1; r <= 3; r++) begin
      issue_en = 1; issue_rd = r[4:0];
      step();
    end
    idle();
    #1;
    chk("t5_cnt3", {58'd0, busy_cnt}, 64'd3);
    flush = 1; wr_en = 1; wr_addr = 2; wr_data = 64'h7; issue_en = 1; issue_rd = 4;
    rd_addr = {5'd1, 5'd2};
    step();
    idle();
    #1;
    chk("t5_cnt0", {58'd0, busy_cnt}, 64'd0);
    chk("t5_busy", {62'd0, rd_busy}, 64'd0);
    chk("t5_data", rd_data[63:0], 64'h7);

    // 6: reset beats a concurrent write to a busy register
    issue_en = 1; issue_rd = 4; rd_addr = {5'd4, 5'd4};
    step();
    idle();
    rst = 1; wr_en = 1; wr_addr = 4; wr_data = 64'h55;
    step();
    idle();
    #1;
    chk("t6_data", rd_data[63:0], 64'd0);
    chk("t6_busy", {62'd0, rd_busy}, 64'd0);
    chk("t6_cnt", {58'd0, busy_cnt}, 64'd0);

    // random traffic concentrated on a few registers to provoke hazards
    for (int n = 0; n < 600; n++) begin
      rst      = ($urandom_range(0, 79) == 0);
      flush    = ($urandom_range(0, 19) == 0);
      wr_en    = ($urandom_range(0, 2) == 0);
      wr_addr  = 5'($urandom_range(0, 7));
      wr_data  = {$urandom, $urandom};
      issue_en = ($urandom_range(0, 1) == 0);
      issue_rd = ($urandom_range(0, 3) == 0) ? wr_addr : 5'($urandom_range(0, 7));
      rd_addr[4:0] = ($urandom_range(0, 2) == 0) ? wr_addr : 5'($urandom_range(0, 7));
      rd_addr[9:5] = 5'($urandom_range(0, 31));
      step();
    end
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
